ahb_arbiter_n: RTL and testbench

Parametrised N-master AHB arbiter, the successor of the fixed two-master arbiter in the AHB interconnect top. Adds selectable fixed-priority or round-robin arbitration, burst-length-aware grant holding, locked-transfer holding and SPLIT masking. Sits inside the AHB top beside the decoder and muxes, and drives HGRANT, HMASTER and HMASTLOCK.

---
 rtl/ahb_pkg.sv | 52 +++++
 rtl/ahb_arbiter_n_if.sv | 37 +++
 rtl/ahb_rr_picker.sv | 48 ++++
 rtl/ahb_arbiter_n.sv | 142 ++++++++++++++
 tb/tb_ahb_arbiter_n.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB transfer/burst/response encodings and beat lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam int AHB_TRANS_BITS = 2;
    localparam int AHB_BURST_BITS = 3;
    localparam int AHB_RESP_BITS  = 2;
    localparam int AHB_BCNT_BITS  = 4;

    typedef enum logic [AHB_TRANS_BITS-1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [AHB_BURST_BITS-1:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [AHB_RESP_BITS-1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_e;

    // Undefined-length INCR counts as one beat so it never holds the grant.
    function automatic logic [4:0] burst_beats(input hburst_e burst);
        logic [4:0] beats;
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  beats = 5'd4;
            BURST_WRAP8,  BURST_INCR8:  beats = 5'd8;
            BURST_WRAP16, BURST_INCR16: beats = 5'd16;
            default:                    beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_n_if
// Description : Arbitration signal bundle between AHB masters/slaves and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_arbiter_n_if
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MASTER_BITS = 4
) ();

    logic [NUM_MASTERS-1:0]    HBUSREQ;
    logic [NUM_MASTERS-1:0]    HLOCK;
    logic [AHB_TRANS_BITS-1:0] HTRANS;
    logic [AHB_BURST_BITS-1:0] HBURST;
    logic                      HREADY;
    logic [AHB_RESP_BITS-1:0]  HRESP;
    logic [NUM_MASTERS-1:0]    HSPLIT;
    logic [NUM_MASTERS-1:0]    HGRANT;
    logic [MASTER_BITS-1:0]    HMASTER;
    logic                      HMASTLOCK;
    logic [NUM_MASTERS-1:0]    SPLIT_MASK;

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
        output HGRANT, HMASTER, HMASTLOCK, SPLIT_MASK
    );

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
        input  HGRANT, HMASTER, HMASTLOCK, SPLIT_MASK
    );

endinterface
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : ahb_rr_picker
// Description : Combinational lowest-index or rotating-start request picker.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_BITS    = 4
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_BITS-1:0]    i_start,
    input  logic                   i_rr_mode,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [IDX_BITS-1:0]    o_idx,
    output logic                   o_valid
);

    int w_base;
    int w_dist;
    int w_best;

    // The winner is the requester with the smallest wrapped distance from the start slot.
    always_comb begin
        w_base  = i_rr_mode ? int'(i_start) : 0;
        w_dist  = 0;
        w_best  = NUM_MASTERS;
        o_idx   = '0;
        o_valid = 1'b0;
        o_grant = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            w_dist = j - w_base;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_MASTERS;
            end
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IDX_BITS'(j);
            end
        end
        o_valid = (w_best < NUM_MASTERS);
        for (int j = 0; j < NUM_MASTERS; j++) begin
            o_grant[j] = o_valid && (o_idx == IDX_BITS'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_n
// Description : N-master AHB arbiter with burst/lock holding and SPLIT masking.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_n
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_BITS    = 4,
    parameter int ARB_MODE       = 0,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_arbiter_n_if.slave bus
);

    localparam logic [NUM_MASTERS-1:0] c_DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_BITS-1:0] c_DEF_IDX   = MASTER_BITS'(DEFAULT_MASTER);
    localparam logic                   c_RR_MODE   = (ARB_MODE == 1);

    logic [NUM_MASTERS-1:0]   r_grant;
    logic [MASTER_BITS-1:0]   r_grant_idx;
    logic [MASTER_BITS-1:0]   r_master;
    logic                     r_mastlock;
    logic [NUM_MASTERS-1:0]   r_split_mask;
    logic [AHB_BCNT_BITS-1:0] r_burst_cnt;
    logic [MASTER_BITS-1:0]   r_rr_ptr;

    logic [NUM_MASTERS-1:0]   w_eligible;
    logic [MASTER_BITS-1:0]   w_start;
    logic [NUM_MASTERS-1:0]   w_win_onehot;
    logic [MASTER_BITS-1:0]   w_win_idx;
    logic                     w_win_valid;
    logic                     w_owner_split;
    logic                     w_owner_lock;
    logic                     w_resp_first;
    logic                     w_hold;
    logic                     w_rearb;
    logic [NUM_MASTERS-1:0]   w_split_set;
    logic [NUM_MASTERS-1:0]   w_split_nxt;
    logic [4:0]               w_beats;
    logic [AHB_BCNT_BITS-1:0] w_cnt_nxt;

    assign w_eligible = bus.HBUSREQ & ~r_split_mask;

    always_comb begin
        w_start = r_rr_ptr + MASTER_BITS'(1);
        if (r_rr_ptr == MASTER_BITS'(NUM_MASTERS - 1)) begin
            w_start = '0;
        end
    end

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_BITS    (MASTER_BITS)
    ) u_picker (
        .i_req     (w_eligible),
        .i_start   (w_start),
        .i_rr_mode (c_RR_MODE),
        .o_grant   (w_win_onehot),
        .o_idx     (w_win_idx),
        .o_valid   (w_win_valid)
    );

    assign w_owner_split = |(r_split_mask & r_grant);
    assign w_owner_lock  = |(bus.HLOCK & r_grant);
    // First (HREADY low) cycle of a two-cycle RETRY/SPLIT response.
    assign w_resp_first  = !bus.HREADY &&
                           ((bus.HRESP == RESP_RETRY) || (bus.HRESP == RESP_SPLIT));
    assign w_hold        = (r_burst_cnt > AHB_BCNT_BITS'(1)) ||
                           (w_owner_lock && !w_owner_split) || w_resp_first;
    assign w_rearb       = !w_hold || w_owner_split;

    assign w_beats = burst_beats(hburst_e'(bus.HBURST));

    always_comb begin
        w_cnt_nxt = r_burst_cnt;
        if (bus.HREADY) begin
            if (bus.HRESP != RESP_OKAY) begin
                w_cnt_nxt = '0;
            end else if (bus.HTRANS == TRANS_NONSEQ) begin
                w_cnt_nxt = AHB_BCNT_BITS'(w_beats - 5'd1);
            end else if ((bus.HTRANS == TRANS_SEQ) && (r_burst_cnt != '0)) begin
                w_cnt_nxt = r_burst_cnt - AHB_BCNT_BITS'(1);
            end
        end
    end

    always_comb begin
        w_split_set = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_split_set[i] = bus.HREADY && (bus.HRESP == RESP_SPLIT) &&
                             (r_master == MASTER_BITS'(i));
        end
    end

    // Set beats a simultaneous release; the default master can never be parked as split.
    assign w_split_nxt = ((r_split_mask & ~bus.HSPLIT) | w_split_set) & ~c_DEF_GRANT;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_grant      <= c_DEF_GRANT;
            r_grant_idx  <= c_DEF_IDX;
            r_master     <= c_DEF_IDX;
            r_mastlock   <= 1'b0;
            r_split_mask <= '0;
            r_burst_cnt  <= '0;
            r_rr_ptr     <= '0;
        end else begin
            if (w_rearb) begin
                if (w_win_valid) begin
                    r_grant     <= w_win_onehot;
                    r_grant_idx <= w_win_idx;
                    r_rr_ptr    <= w_win_idx;
                end else begin
                    r_grant     <= c_DEF_GRANT;
                    r_grant_idx <= c_DEF_IDX;
                end
            end
            if (bus.HREADY) begin
                r_master   <= r_grant_idx;
                r_mastlock <= w_owner_lock;
            end
            r_burst_cnt  <= w_cnt_nxt;
            r_split_mask <= w_split_nxt;
        end
    end

    assign bus.HGRANT     = r_grant;
    assign bus.HMASTER    = r_master;
    assign bus.HMASTLOCK  = r_mastlock;
    assign bus.SPLIT_MASK = r_split_mask;

    a_grant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(r_grant));
    a_master_range: assert property (@(posedge HCLK) disable iff (HRESET)
                                     int'(r_master) < NUM_MASTERS);

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_arbiter_n
// Description : Directed bench for ahb_arbiter_n, fixed and round-robin instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter_n;

    localparam int N   = 4;
    localparam int MB  = 4;
    localparam int DEF = 0;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic [N-1:0] busreq = '0;
    logic [N-1:0] hlock  = '0;
    logic [N-1:0] hsplit = '0;
    logic [1:0]   htrans = '0;
    logic [2:0]   hburst = '0;
    logic [1:0]   hresp  = '0;
    logic         hready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int rr_exp[5] = '{2, 4, 8, 2, 4};

    typedef struct packed {
        int     g;
        int     m;
        bit     lk;
        bit [N-1:0] mask;
        int     cnt;
        int     rr;
    } model_t;

    model_t mf;
    model_t mr;

    ahb_arbiter_n_if #(.NUM_MASTERS(N), .MASTER_BITS(MB)) if_fx ();
    ahb_arbiter_n_if #(.NUM_MASTERS(N), .MASTER_BITS(MB)) if_rr ();

    assign if_fx.HBUSREQ = busreq;  assign if_rr.HBUSREQ = busreq;
    assign if_fx.HLOCK   = hlock;   assign if_rr.HLOCK   = hlock;
    assign if_fx.HTRANS  = htrans;  assign if_rr.HTRANS  = htrans;
    assign if_fx.HBURST  = hburst;  assign if_rr.HBURST  = hburst;
    assign if_fx.HREADY  = hready;  assign if_rr.HREADY  = hready;
    assign if_fx.HRESP   = hresp;   assign if_rr.HRESP   = hresp;
    assign if_fx.HSPLIT  = hsplit;  assign if_rr.HSPLIT  = hsplit;

    ahb_arbiter_n #(.NUM_MASTERS(N), .MASTER_BITS(MB), .ARB_MODE(0), .DEFAULT_MASTER(DEF))
        u_dut_fx (.HCLK(clk), .HRESET(rst), .bus(if_fx.slave));
    ahb_arbiter_n #(.NUM_MASTERS(N), .MASTER_BITS(MB), .ARB_MODE(1), .DEFAULT_MASTER(DEF))
        u_dut_rr (.HCLK(clk), .HRESET(rst), .bus(if_rr.slave));

    initial forever #5 clk = ~clk;

    function automatic model_t model_reset();
        model_t s;
        s.g = DEF; s.m = DEF; s.lk = 1'b0; s.mask = '0; s.cnt = 0; s.rr = 0;
        return s;
    endfunction

    function automatic model_t model_step(model_t s, int mode);
        model_t n;
        int win, j, beats;
        bit found, own_split, own_lock, hold;
        n = s; win = DEF; found = 1'b0; own_split = 1'b0; own_lock = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (mode == 1) ? (s.rr + 1 + k) % N : k;
            if (!found && busreq[j] && !s.mask[j]) begin
                win = j; found = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (k == s.g) begin
                own_split = s.mask[k];
                own_lock  = hlock[k];
            end
        end
        hold = (s.cnt > 1) || (own_lock && !own_split) || (!hready && (hresp >= 2));
        if (!hold || own_split) begin
            n.g = win;
            if (found) n.rr = win;
        end
        beats = (hburst < 2) ? 1 : (4 << ((int'(hburst) - 2) / 2));
        if (hready) begin
            n.m  = s.g;
            n.lk = own_lock;
            if (hresp != 0)        n.cnt = 0;
            else if (htrans == 2)  n.cnt = beats - 1;
            else if (htrans == 3)  n.cnt = (s.cnt > 0) ? s.cnt - 1 : 0;
        end
        n.mask = s.mask & ~hsplit;
        for (int k = 0; k < N; k++) begin
            if (hready && hresp == 3 && k == s.m && k != DEF) n.mask[k] = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mf <= model_reset();
            mr <= model_reset();
        end else begin
            mf <= model_step(mf, 0);
            mr <= model_step(mr, 1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("mdl_fx_hgrant",  int'(if_fx.HGRANT),     1 << mf.g);
        chk("mdl_fx_hmaster", int'(if_fx.HMASTER),    mf.m);
        chk("mdl_fx_lock",    int'(if_fx.HMASTLOCK),  int'(mf.lk));
        chk("mdl_fx_mask",    int'(if_fx.SPLIT_MASK), int'(mf.mask));
        chk("mdl_rr_hgrant",  int'(if_rr.HGRANT),     1 << mr.g);
        chk("mdl_rr_hmaster", int'(if_rr.HMASTER),    mr.m);
        chk("mdl_rr_lock",    int'(if_rr.HMASTLOCK),  int'(mr.lk));
        chk("mdl_rr_mask",    int'(if_rr.SPLIT_MASK), int'(mr.mask));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        busreq = '0; hlock = '0; hsplit = '0;
        htrans = '0; hburst = '0; hresp = '0; hready = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        chk("rst_grant",   int'(if_fx.HGRANT),     1);
        chk("rst_hmaster", int'(if_fx.HMASTER),    0);
        chk("rst_lock",    int'(if_fx.HMASTLOCK),  0);
        chk("rst_mask",    int'(if_fx.SPLIT_MASK), 0);
        cyc(2);
        chk("idle_grant",  int'(if_fx.HGRANT),     1);

        // Fixed priority: master 1 beats master 2.
        busreq = 4'b0110;
        cyc(1);
        chk("fix_grant",       int'(if_fx.HGRANT),  2);
        chk("fix_hmaster_lag", int'(if_fx.HMASTER), 0);
        cyc(1);
        chk("fix_hmaster",     int'(if_fx.HMASTER), 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("fix_no_m2", int'(if_fx.HGRANT), 2);
        end

        // Round-robin rotation over masters 1..3.
        do_reset();
        busreq = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("rr_seq", int'(if_rr.HGRANT), rr_exp[k]);
        end

        // INCR4 by master 1 with two wait states; master 2 waiting.
        do_reset();
        busreq = 4'b0010;
        cyc(2);
        chk("burst_owner", int'(if_fx.HMASTER), 1);
        htrans = 2'd2; hburst = 3'd3; busreq = 4'b0110;
        cyc(1);
        chk("burst_b1", int'(if_fx.HGRANT), 2);
        htrans = 2'd3; busreq = 4'b0100;
        cyc(1);
        chk("burst_b2", int'(if_fx.HGRANT), 2);
        hready = 1'b0;
        cyc(2);
        chk("burst_wait_grant",   int'(if_fx.HGRANT),  2);
        chk("burst_wait_hmaster", int'(if_fx.HMASTER), 1);
        hready = 1'b1;
        cyc(1);
        chk("burst_b3", int'(if_fx.HGRANT), 2);
        cyc(1);
        chk("burst_b4_move", int'(if_fx.HGRANT), 4);
        htrans = 2'd0;

        // Locked singles from master 2 while master 1 requests.
        do_reset();
        busreq = 4'b0100; hlock = 4'b0100;
        cyc(2);
        chk("lock_hmaster", int'(if_fx.HMASTER),   2);
        chk("lock_mlock",   int'(if_fx.HMASTLOCK), 1);
        busreq = 4'b0110; htrans = 2'd2; hburst = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("lock_hold_grant", int'(if_fx.HGRANT),    4);
            chk("lock_hold_mlock", int'(if_fx.HMASTLOCK), 1);
        end
        hlock = 4'b0000; htrans = 2'd0;
        cyc(1);
        chk("lock_release", int'(if_fx.HGRANT), 2);

        // SPLIT of master 1, release, then simultaneous set and clear.
        do_reset();
        busreq = 4'b0110;
        cyc(2);
        chk("split_owner", int'(if_fx.HMASTER), 1);
        hready = 1'b0; hresp = 2'd3;
        cyc(1);
        chk("split_c1_grant", int'(if_fx.HGRANT),     2);
        chk("split_c1_mask",  int'(if_fx.SPLIT_MASK), 0);
        hready = 1'b1;
        cyc(1);
        chk("split_set", int'(if_fx.SPLIT_MASK), 2);
        hresp = 2'd0;
        cyc(1);
        chk("split_grant_move", int'(if_fx.HGRANT), 4);
        hsplit = 4'b0010;
        cyc(1);
        chk("split_clear", int'(if_fx.SPLIT_MASK), 0);
        hsplit = 4'b0000;
        cyc(1);
        chk("split_regrant", int'(if_fx.HGRANT), 2);
        cyc(1);
        chk("split_owner2", int'(if_fx.HMASTER), 1);
        hresp = 2'd3; hsplit = 4'b0010;
        cyc(1);
        chk("split_set_wins", int'(if_fx.SPLIT_MASK), 2);
        hresp = 2'd0; hsplit = 4'b0000;

        // SPLIT aimed at the default master is ignored.
        do_reset();
        hresp = 2'd3;
        cyc(1);
        chk("split_default", int'(if_fx.SPLIT_MASK), 0);
        hresp = 2'd0;

        // Reset asserted in the middle of an INCR8.
        do_reset();
        busreq = 4'b0010;
        cyc(2);
        htrans = 2'd2; hburst = 3'd5;
        cyc(1);
        htrans = 2'd3;
        cyc(1);
        chk("mid_pre_hmaster", int'(if_fx.HMASTER), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_grant",   int'(if_fx.HGRANT),    1);
        chk("mid_rst_hmaster", int'(if_fx.HMASTER),   0);
        chk("mid_rst_lock",    int'(if_fx.HMASTLOCK), 0);
        busreq = '0; htrans = '0; hburst = '0;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
